fetch_queue: RTL and testbench

//  Consumer end of the PC/fetch address stream. Buffers {pc, instr} pairs from
//  the IF stage (program_counter + instruction memory) and hands them in order to ID.

---
 rtl/fetch_queue_pkg.sv | 31 +++
 rtl/fetch_queue_mem.sv | 27 ++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the fetch queue: empty-queue output
// values and the per-cycle operation decode.
package fetch_queue_pkg;

  // Values presented on the head outputs while the queue is empty.
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_INVALID = 32'hFFFF_FFFC;

  // What the queue does at a clock edge.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_FLUSH
  } fq_op_e;

  // Flush wins over everything; otherwise push/pop combine independently.
  function automatic fq_op_e decode_op(input logic flush,
                                       input logic push,
                                       input logic pop);
    fq_op_e op;
    if (flush)             op = OP_FLUSH;
    else if (push && pop)  op = OP_BOTH;
    else if (push)         op = OP_PUSH;
    else if (pop)          op = OP_POP;
    else                   op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for the fetch queue: DEPTH x W register array, one synchronous
// write port, one asynchronous read port, contents not reset.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the incoming entry into its slot.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Zero-cycle read of the addressed slot for show-ahead output.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order buffer of {pc, instr} pairs between instruction fetch and decode.
// Show-ahead head output, flush on redirect, sticky overflow flag.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_pc,
  input  logic [DW-1:0]          in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_pc,
  output logic [DW-1:0]          out_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          drop_err_q;
  logic          push;
  logic          pop;
  logic          we;
  fq_op_e        op;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Handshake and operation decode; ready/valid come only from occupancy.
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    op        = decode_op(flush, push, pop);
    we        = (op == OP_PUSH) || (op == OP_BOTH);
    wdata     = {in_pc, in_instr};
  end

  // Head outputs fall back to the empty-queue values when nothing is held.
  always_comb begin
    count = count_q;
    if (out_valid) begin
      out_pc    = rdata[EW-1:DW];
      out_instr = rdata[DW-1:0];
    end else begin
      out_pc    = AW'(PC_INVALID);
      out_instr = DW'(NOP);
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      case (op)
        OP_FLUSH: begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          count_q <= '0;
        end
        OP_PUSH: begin
          wr_ptr  <= wr_ptr + PW'(1);
          count_q <= count_q + CW'(1);
        end
        OP_POP: begin
          rd_ptr  <= rd_ptr + PW'(1);
          count_q <= count_q - CW'(1);
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + PW'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky record of a pair offered while the queue was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err_q <= 1'b0;
    end else if (in_valid && !in_ready && !flush) begin
      drop_err_q <= 1'b1;
    end
  end

  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed test of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_pc = '0;
  logic [DW-1:0] in_instr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic [2:0]    count;
  logic          drop_err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model: ordered list of {pc, instr} plus the sticky flag.
  logic [63:0] mq[$];
  logic        m_err = 1'b0;

  fetch_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count", 64'(count), 64'(n));
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
    chk("out_pc", 64'(out_pc), (n != 0) ? 64'(mq[0][63:32]) : 64'hFFFF_FFFC);
    chk("out_instr", 64'(out_instr), (n != 0) ? 64'(mq[0][31:0]) : 64'h0);
    chk("drop_err", 64'(drop_err), 64'(m_err));
  endtask

  // Apply the queue rules to the model using the inputs present at this edge.
  task automatic model_update();
    int  n;
    bit  do_push;
    bit  do_pop;
    n = mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      do_push = in_valid && (n != DEPTH);
      do_pop  = out_ready && (n != 0);
      if (in_valid && n == DEPTH) m_err = 1'b1;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_instr});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    mq.delete();
    m_err = 1'b0;
    #4 reset = 1'b0;
  endtask

  // Every cycle, compare DUT outputs against the model away from the edge.
  always @(negedge clk) begin
    if (cmp_en) check_model();
  end

  initial begin
    // 1. reset then idle
    reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'hFFFF_FFFC);
    chk("rst_out_instr", 64'(out_instr), 64'h0);

    // 2. fill with out_ready=0, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(4 * i);
      in_instr = 32'hA0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(4 * i));
      chk("drain_instr", 64'(out_instr), 64'(32'hA0 + 32'(i)));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);

    // 3. steady stream: one in, one out per cycle
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc    = 32'(4 * i);
      in_instr = 32'hB0 + 32'(i);
      if (i > 0) begin
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_pc", 64'(out_pc), 64'(4 * (i - 1)));
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_last_pc", 64'(out_pc), 64'h24);
    tick();
    out_ready = 1'b0;
    chk("stream_end_count", 64'(count), 64'd0);

    // 4. flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h10 + 32'(4 * i);
      in_instr = 32'hC0 + 32'(i);
      tick();
    end
    chk("preflush_count", 64'(count), 64'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h30;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_pc    = 32'h40;
    in_instr = 32'hD0;
    tick();
    in_valid = 1'b0;
    chk("postflush_pc", 64'(out_pc), 64'h40);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5. overflow sets sticky drop_err without disturbing contents
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = (i < 4) ? 32'h50 + 32'(4 * i) : 32'h99;
      in_instr = 32'hE0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("ovf_drop_err", 64'(drop_err), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pc", 64'(out_pc), 64'(32'h50 + 32'(4 * i)));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_sticky", 64'(drop_err), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(drop_err), 64'd0);
    tick();

    // 6. asynchronous reset mid-cycle with two entries held
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h80 + 32'(4 * i);
      in_instr = 32'hF0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("prerst_count", 64'(count), 64'd2);
    #1 reset = 1'b1;
    mq.delete();
    m_err = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_out_pc", 64'(out_pc), 64'hFFFF_FFFC);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    in_pc    = 32'h100;
    in_instr = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("postrst_pc", 64'(out_pc), 64'h100);
    chk("postrst_instr", 64'(out_instr), 64'h1234_5678);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
